// File: rtl/pgc_pkg.sv
// Shared definitions for the power-gate controller: state codes, default
// timing constants and the state-to-output decode used by the controller.
package pgc_pkg;

  typedef enum logic [2:0] {
    ACTIVE  = 3'd0,
    ISOLATE = 3'd1,
    SAVE    = 3'd2,
    SLEEP   = 3'd3,
    WAKE    = 3'd4,
    RESTORE = 3'd5,
    DEISO   = 3'd6
  } pgc_state_t;

  localparam int DEF_IDLE_LIMIT    = 16;
  localparam int DEF_SETTLE_CYCLES = 8;

  typedef struct packed {
    logic sleep;
    logic iso_en;
    logic ret_save;
    logic ret_restore;
    logic pwr_ready;
  } pgc_out_t;

  // Moore output decode; an unknown code decodes like ACTIVE because it recovers there.
  function automatic pgc_out_t decode_outputs(input pgc_state_t st);
    pgc_out_t o;
    o = '0;
    case (st)
      ACTIVE: begin
        o.pwr_ready = 1'b1;
      end
      ISOLATE: begin
        o.iso_en = 1'b1;
      end
      SAVE: begin
        o.iso_en   = 1'b1;
        o.ret_save = 1'b1;
      end
      SLEEP: begin
        o.sleep  = 1'b1;
        o.iso_en = 1'b1;
      end
      WAKE: begin
        o.iso_en = 1'b1;
      end
      RESTORE: begin
        o.iso_en      = 1'b1;
        o.ret_restore = 1'b1;
      end
      DEISO: begin
        o.pwr_ready = 1'b0;
      end
      default: begin
        o.pwr_ready = 1'b1;
      end
    endcase
    return o;
  endfunction

endpackage

// File: rtl/pgc_timer.sv
// Loadable 8-bit down-counter with a done flag; stops at zero rather than wrapping.
module pgc_timer
  import pgc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       en,
  output logic       done
);

  logic [7:0] count_r;

  // Load has priority over counting; the count saturates at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= 8'd0;
    end else if (load) begin
      count_r <= load_val;
    end else if (en && (count_r != 8'd0)) begin
      count_r <= count_r - 8'd1;
    end else begin
      count_r <= count_r;
    end
  end

  assign done = (count_r == 8'd0);

endmodule

// File: rtl/power_gate_ctrl.sv
// MTCMOS power-gate sequencer: isolate, save, sleep, settle, restore, de-isolate,
// with abort back through DEISO when the domain is needed before sleep is asserted.
module power_gate_ctrl
  import pgc_pkg::*;
#(
  parameter int IDLE_LIMIT    = DEF_IDLE_LIMIT,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sleep_en,
  input  logic       activity,
  input  logic       wake_req,
  output logic       sleep,
  output logic       iso_en,
  output logic       ret_save,
  output logic       ret_restore,
  output logic       pwr_ready,
  output logic [2:0] state_o
);

  localparam logic [7:0] IDLE_LAST   = 8'(IDLE_LIMIT - 1);
  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

  pgc_state_t state_r;
  pgc_state_t state_s;
  logic [7:0] idle_cnt_r;
  logic [7:0] idle_cnt_s;
  pgc_out_t   out_r;
  logic       idle_cond_s;
  logic       wake_ev_s;
  logic       timer_load_s;
  logic       timer_en_s;
  logic       timer_done_s;

  assign idle_cond_s = sleep_en & ~activity & ~wake_req;
  assign wake_ev_s   = wake_req | activity;

  // The timer is loaded with SETTLE_CYCLES-1 on WAKE entry so WAKE spans SETTLE_CYCLES cycles.
  pgc_timer u_settle (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load_s),
    .load_val (SETTLE_LOAD),
    .en       (timer_en_s),
    .done     (timer_done_s)
  );

  // Next-state, idle-count and settle-timer control.
  always_comb begin
    state_s      = state_r;
    idle_cnt_s   = 8'd0;
    timer_load_s = 1'b0;
    timer_en_s   = 1'b0;
    case (state_r)
      ACTIVE: begin
        if (idle_cond_s) begin
          if (idle_cnt_r == IDLE_LAST) begin
            state_s    = ISOLATE;
            idle_cnt_s = 8'd0;
          end else begin
            state_s    = ACTIVE;
            idle_cnt_s = idle_cnt_r + 8'd1;
          end
        end else begin
          state_s    = ACTIVE;
          idle_cnt_s = 8'd0;
        end
      end
      ISOLATE: begin
        if (wake_ev_s) begin
          state_s = DEISO;
        end else begin
          state_s = SAVE;
        end
      end
      SAVE: begin
        if (wake_ev_s) begin
          state_s = DEISO;
        end else begin
          state_s = SLEEP;
        end
      end
      SLEEP: begin
        if (wake_ev_s) begin
          state_s      = WAKE;
          timer_load_s = 1'b1;
        end else begin
          state_s = SLEEP;
        end
      end
      WAKE: begin
        if (timer_done_s) begin
          state_s = RESTORE;
        end else begin
          state_s    = WAKE;
          timer_en_s = 1'b1;
        end
      end
      RESTORE: begin
        state_s = DEISO;
      end
      DEISO: begin
        state_s = ACTIVE;
      end
      default: begin
        state_s = ACTIVE;
      end
    endcase
  end

  // State, idle count and outputs register together so outputs change with the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ACTIVE;
      idle_cnt_r <= 8'd0;
      out_r      <= decode_outputs(ACTIVE);
    end else begin
      state_r    <= state_s;
      idle_cnt_r <= idle_cnt_s;
      out_r      <= decode_outputs(state_s);
    end
  end

  assign sleep       = out_r.sleep;
  assign iso_en      = out_r.iso_en;
  assign ret_save    = out_r.ret_save;
  assign ret_restore = out_r.ret_restore;
  assign pwr_ready   = out_r.pwr_ready;
  assign state_o     = state_r;

endmodule

// File: doc/power_gate_ctrl.md
POWER_GATE_CTRL -- requirements
Module: power_gate_ctrl

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- IDLE_LIMIT, 16, consecutive idle cycles before sleep entry (range 1..255).
- SETTLE_CYCLES, 8, cycles in WAKE before restore (range 1..255).
REQ-002 Clock is clk and reset is rst; one clock; reset is asynchronous and active-high.
REQ-003 Ports SHALL be (name, direction, width, meaning):
- clk, input, 1, sole clock, rising edge.
- rst, input, 1, asynchronous active-high reset.
- sleep_en, input, 1, software permission to enter sleep.
- activity, input, 1, domain busy this cycle.
- wake_req, input, 1, external wake request.
- sleep, output, 1, drives sleep of the downstream MTCMOS flip-flops (1 = header off).
- iso_en, output, 1, clamp the gated domain's outputs.
- ret_save, output, 1, one-cycle pulse to retention latches: save.
- ret_restore, output, 1, one-cycle pulse to retention latches: restore.
- pwr_ready, output, 1, domain powered and unisolated.
- state_o, output, 3, current state code.

Function
REQ-004 FSM states SHALL be ACTIVE=0, ISOLATE=1, SAVE=2, SLEEP=3, WAKE=4, RESTORE=5, DEISO=6; code 7 is illegal and SHALL go to ACTIVE on the next edge.
REQ-005 Outputs SHALL be Moore, registered, and decoded from state only:
- sleep=1 in SLEEP only.
- iso_en=1 in ISOLATE, SAVE, SLEEP, WAKE, RESTORE.
- ret_save=1 in SAVE only.
- ret_restore=1 in RESTORE only.
- pwr_ready=1 in ACTIVE only.
REQ-006 In ACTIVE, the 8-bit idle counter SHALL increment each cycle with sleep_en=1, activity=0 and wake_req=0, and SHALL clear to 0 otherwise.
REQ-007 ACTIVE->ISOLATE SHALL occur on the edge where the counter equals IDLE_LIMIT-1 and the idle condition holds, i.e. after exactly IDLE_LIMIT idle cycles; the counter SHALL then clear.
REQ-008 ISOLATE->SAVE and SAVE->SLEEP SHALL take one cycle each, unless wake_req=1 or activity=1 is sampled in ISOLATE or SAVE; in that case the next state SHALL be DEISO (abort, sleep never asserted).
REQ-009 SLEEP SHALL hold until wake_req=1 or activity=1 is sampled; next state is WAKE. sleep_en=0 alone SHALL NOT wake.
REQ-010 WAKE SHALL last exactly SETTLE_CYCLES cycles, timed by the settle counter, then go to RESTORE; wake_req and activity SHALL be ignored in WAKE, RESTORE and DEISO.
REQ-011 RESTORE->DEISO->ACTIVE SHALL take one cycle each; the idle counter SHALL be 0 on ACTIVE entry.
REQ-012 The wake latency from SLEEP-exit edge to pwr_ready=1 SHALL be SETTLE_CYCLES+2 cycles.
REQ-013 sleep and ret_save SHALL never both be 1; ret_restore SHALL never be 1 while sleep=1.

Reset
REQ-014 rst=1 SHALL immediately, without a clock, force: state ACTIVE, both counters 0, sleep=0, iso_en=0, ret_save=0, ret_restore=0, pwr_ready=1, state_o=0.
REQ-015 Reset mid-operation, including in SLEEP, SHALL abandon the sequence without any restore pulse; the first post-reset edge evaluates from ACTIVE.

Structure
REQ-016 A shared package pgc_pkg SHALL hold the state enumeration codes and the default IDLE_LIMIT and SETTLE_CYCLES constants.
REQ-017 One sub-module, pgc_timer, SHALL implement a loadable 8-bit down-counter with a done flag, instantiated for the settle count; the idle counter stays inline.

Verification (IDLE_LIMIT=8, SETTLE_CYCLES=4)
REQ-018 The bench SHALL cover the following directed scenarios:
- Entry: sleep_en=1, activity=0 from cycle 0. Required: ISOLATE at edge 8, ret_save pulse at edge 9, sleep=1 from edge 10, pwr_ready=0 from edge 8.
- Idle interrupt: activity=1 for one cycle at idle count 6. Required: counter clears; ISOLATE only after 8 further idle cycles.
- Wake: wake_req pulse in SLEEP. Required: sleep=0 next edge; WAKE for 4 cycles; ret_restore one cycle; iso_en=0 in DEISO; pwr_ready=1 6 cycles after the SLEEP exit.
- Abort: wake_req=1 in SAVE. Required: DEISO next, then ACTIVE; sleep never 1; no ret_restore.
- Async reset: rst pulsed mid-cycle in SLEEP. Required: sleep=0, iso_en=0, pwr_ready=1 before the next clk edge.
- Invariant: random activity/wake_req/sleep_en over 2000 cycles. Required: REQ-013 assertions never fire.
